// File: rtl/rho_rotate_stage.sv
// Keccak rho stage: buffers a serial 1600-bit theta result, then emits one
// rotated 25-bit slice per handshake with each lane shifted by its rho offset.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// FILL  | accepting theta bits slice-major into mem
// DRAIN | presenting rotated slice dz until out_ready takes it
module rho_rotate_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [24:0] out_slice,
    output logic [5:0]  out_z,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t      state, state_nx;
    logic [4:0]  c25;
    logic [5:0]  c64;
    logic [5:0]  dz;
    logic        done_q;
    logic        fill_acc;
    logic        drain_acc;
    logic        fill_last;
    logic [24:0] mem [64];

    // Rho offset of lane i = 5*y + x.
    function automatic logic [5:0] rho_off(input logic [4:0] lane);
        case (lane)
            5'd0:    rho_off = 6'd0;
            5'd1:    rho_off = 6'd1;
            5'd2:    rho_off = 6'd62;
            5'd3:    rho_off = 6'd28;
            5'd4:    rho_off = 6'd27;
            5'd5:    rho_off = 6'd36;
            5'd6:    rho_off = 6'd44;
            5'd7:    rho_off = 6'd6;
            5'd8:    rho_off = 6'd55;
            5'd9:    rho_off = 6'd20;
            5'd10:   rho_off = 6'd3;
            5'd11:   rho_off = 6'd10;
            5'd12:   rho_off = 6'd43;
            5'd13:   rho_off = 6'd25;
            5'd14:   rho_off = 6'd39;
            5'd15:   rho_off = 6'd41;
            5'd16:   rho_off = 6'd45;
            5'd17:   rho_off = 6'd15;
            5'd18:   rho_off = 6'd21;
            5'd19:   rho_off = 6'd8;
            5'd20:   rho_off = 6'd18;
            5'd21:   rho_off = 6'd2;
            5'd22:   rho_off = 6'd61;
            5'd23:   rho_off = 6'd56;
            5'd24:   rho_off = 6'd14;
            default: rho_off = 6'd0;
        endcase
    endfunction

    assign fill_last = (c64 == 6'd63) && (c25 == 5'd24);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fill_acc  = 1'b0;
        drain_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                fill_acc = in_valid;
                if (in_valid && fill_last) state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                drain_acc = out_ready;
                if (out_ready && dz == 6'd63) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            c25    <= 5'd0;
            c64    <= 6'd0;
            dz     <= 6'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= drain_acc && (dz == 6'd63);
            if (state == IDLE && start) begin
                c25 <= 5'd0;
                c64 <= 6'd0;
            end
            if (fill_acc) begin
                if (c25 == 5'd24) begin
                    c25 <= 5'd0;
                    c64 <= c64 + 6'd1;
                end else begin
                    c25 <= c25 + 5'd1;
                end
                if (fill_last) dz <= 6'd0;
            end
            if (drain_acc) dz <= dz + 6'd1;
        end
    end

    // State storage carries no reset; every fill overwrites all 1600 bits.
    always_ff @(posedge clk) begin
        if (fill_acc) mem[c64][5'd24 - c25] <= in_bit;
    end

    always_comb begin
        out_slice = 25'd0;
        if (out_valid) begin
            for (int i = 0; i < 25; i++) begin
                out_slice[5'(24 - i)] = mem[dz - rho_off(5'(i))][5'(24 - i)];
            end
        end
    end

    assign out_z    = out_valid ? dz : 6'd0;
    assign out_last = out_valid && (dz == 6'd63);
    assign busy     = (state != IDLE);
    assign done     = done_q;

endmodule

// File: doc/rho_rotate_stage.md
# rho_rotate_stage

Rho stage of the Keccak-f round. It sits directly downstream of the column-parity (theta) datapath. It consumes theta's serial result stream: one bit per accepted cycle, slice-major, 64 slices × 25 bits. It buffers the full 1600-bit state, then emits one rotated 25-bit slice per handshake. Each lane is rotated by its fixed Keccak rho offset.

## Interface
- No parameters. Widths are fixed: 25 bits per slice, 64 slices.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a fill when idle.
- in_valid  in  1  in_bit is valid.
- in_bit  in  1  theta result bit.
- in_ready  out  1  stage accepts in_bit this cycle.
- out_ready  in  1  consumer accepts out_slice this cycle.
- out_valid  out  1  out_slice is valid.
- out_slice  out  25  rotated slice; lane index i maps to out_slice[24-i].
- out_z  out  6  depth of the current out_slice.
- out_last  out  1  out_valid and out_z==63.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the final slice is accepted.

## Operation
- Lane index i = 5*y + x, with x the column and y the row, 0..4. Input order: for z = 0..63, for i = 0..24. This matches theta's writer order, in which bit i of slice z is pin[24-i].
- Storage: 64 × 25-bit register array mem[z]; no reset on contents.
- Rho offsets r(x,y):
  - y=0: 0, 1, 62, 28, 27 for x=0..4.
  - y=1: 36, 44, 6, 55, 20.
  - y=2: 3, 10, 43, 25, 39.
  - y=3: 41, 45, 15, 21, 8.
  - y=4: 18, 2, 61, 56, 14.
- Output rule: out_slice[24-i] = mem[(out_z - r_i) mod 64][24-i]. Address arithmetic is 6-bit and wraps naturally. Equivalently, an input bit at depth z0 appears at output depth (z0 + r_i) mod 64.
- FSM:
  - IDLE: in_ready=0, out_valid=0. On start go to FILL, with bit counter c25=0 and depth counter c64=0.
  - FILL: in_ready=1.
    - On in_valid, write in_bit to mem[c64][24-c25], then increment c25.
    - When c25 wraps 24→0, increment c64.
    - The accept at c64=63, c25=24 moves the state to DRAIN and clears the drain counter dz.
  - DRAIN: out_valid=1, out_z=dz.
    - On out_ready, increment dz.
    - The accept at dz=63 moves the state to IDLE and asserts done for the next cycle.
- start is ignored outside IDLE. in_valid is ignored outside FILL. out_ready is ignored outside DRAIN.
- When out_valid=0, out_slice and out_z are driven 0.
- in_valid gaps stall the fill without loss. out_ready low holds out_slice and out_z stable.

## Timing
- Reset values: state IDLE; counters 0; in_ready, out_valid, out_last, busy, done all 0; out_slice 0; out_z 0.
- A reset in any state aborts the operation within one cycle. Partial mem content is don't-care; the next start refills it completely.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready.
- The write lands on the clock edge of the accepting cycle.
- out_slice is combinational from mem and the registered dz, so it is valid in the same cycle as out_valid.
- Latency: out_valid rises the cycle after the 1600th input accept.
- Throughput: minimum 1600 + 64 cycles per state, plus 1 cycle IDLE/start.
- done is high exactly one cycle, coincident with the first IDLE cycle. busy is 0 in that cycle.
- A start asserted in the same cycle as done is honoured: it enters FILL next cycle.

## Test plan
- All-zero fill with continuous in_valid=1 and out_ready=1 → 64 slices of 0; out_z 0..63; out_last only at out_z=63; done pulses once; total 1665 cycles from start.
- Single 1 at lane (1,0) z=0 (i=1) → only out_slice[23] set, only at out_z=1. Single 1 at lane (0,0) z=7 → out_slice[24] set at out_z=7.
- Wrap-around: 1 at lane (2,0) z=5 → out_slice[22] at out_z=3. 1 at lane (4,4) z=60 → out_slice[0] at out_z=10.
- Random 1600-bit state with random in_valid gaps and out_ready backpressure → outputs match a rho reference model. out_slice and out_z stay stable while out_ready=0. No bit is lost or duplicated.
- rst asserted mid-FILL (after 700 bits) and mid-DRAIN (at dz=20) → next cycle IDLE with all outputs 0. A following start with a fresh state produces correct output.
- start pulsed during FILL and during DRAIN → ignored, with no counter disturbance. start coincident with done → FILL entered next cycle.
